scalar_bank_arb: RTL
====================

Name: scalar_bank_arb

Overview:
- Round-robin arbiter that shares the two ports of one dual-port scalar bank among NREQ scalar requesters.
- Grants at most two requests per cycle, one per bank port.
- Blocks same-word port pairs where either side writes.
- Routes the bank's 1-cycle read data back to the owning requester.
- Sits between xcache scalar clients and a scalar bank instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BYTE_AW, 12, byte address width of bank and requesters.
- DW, 32, data width.
- IW, $clog2(NREQ), requester index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- req  in  NREQ  request valid, one bit per requester.
- req_we  in  NREQ  1=write, 0=read.
- req_len  in  2*NREQ  packed; 0=byte, 1=half, 3=word.
- req_adr  in  BYTE_AW*NREQ  packed byte address.
- req_din  in  DW*NREQ  packed, unshifted write data.
- gnt  out  NREQ  request accepted this cycle.
- rd_vld  out  NREQ  read data valid for requester i.
- rd_data  out  DW*NREQ  packed read data, already byte-aligned by the bank.
- bank_re0, bank_re1  out  1  bank read enables.
- bank_we0, bank_we1  out  1  bank write enables.
- bank_len0, bank_len1  out  2  bank access length.
- bank_adr0, bank_adr1  out  BYTE_AW  bank byte address.
- bank_din0, bank_din1  out  DW  bank write data.
- bank_dout0, bank_dout1  in  DW  bank read data (1-cycle latency).
- bank_dout0_vld, bank_dout1_vld  in  1  bank read-valid.

Behaviour:
- Clock is clk; reset is rstn, asynchronous, active-low.
- Reset state: rr_ptr=0, own0_vld=own1_vld=0, own0_idx=own1_idx=0. Hence gnt=0, rd_vld=0 and rd_data=0 while rstn is low.
- Arbitration is combinational within the cycle; the bank samples port signals on the next clk edge.
- Port 0 goes to the first requester with req=1, scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
- Port 1 goes to the next requester after the port-0 winner in the same rotation that:
  - has req=1, and
  - is not in conflict with the port-0 winner.
- Conflict rule:
  - Conflict = equal word address (adr[BYTE_AW-1:2]) and either request is a write.
  - Two reads of the same word never conflict.
  - A conflicting candidate is skipped; scanning continues.
- gnt[i]=1 only for granted requesters. A requester holds req and its fields stable until gnt.
- Ungranted port: re=0, we=0, len/adr/din=0.
- Granted port: re=~req_we, we=req_we; len, adr and din pass through unchanged.
- Pointer update:
  - If any grant: rr_ptr <= (last granted index + 1) mod NREQ. "Last" is the port-1 winner if present, else the port-0 winner.
  - No grant: rr_ptr holds.
- Ownership tracking, every cycle: ownP_vld <= port P granted a read; ownP_idx <= its index. Writes set no owner.
- Read return:
  - rd_vld[own0_idx] is asserted when own0_vld & bank_dout0_vld, with rd_data slice = bank_dout0.
  - Port 1 is handled the same way with own1 and bank_dout1.
  - Total read latency: gnt cycle + 1.
  - Slices of requesters with no valid return are driven 0.
- A requester can receive a grant in back-to-back cycles and rd_vld in back-to-back cycles.
- One requester never holds both ports in the same cycle.
- own*_vld with bank_dout*_vld=0 is a bank protocol error. In that case rd_vld stays 0; assertion only, no recovery logic.
- Reset mid-operation: pending returns are dropped and rd_vld is forced 0 immediately. Any bank write already clocked remains in memory.
- Starvation freedom: any held request is granted within NREQ cycles.

Test Plan:
- Reset, then req=4'b0101, both reads, adr 0x010/0x020 -> gnt=0101; req0 on port 0, req2 on port 1. Next cycle rd_vld=0101 with each requester's bank data. rr_ptr=3.
- req0 write word 0x040 len=3 and req1 read byte 0x041, rr_ptr=0 -> cycle 1 gnt=0001 (conflict). Cycle 2 gnt=0010, rd_data[1]=updated byte.
- req1 and req3 both read adr 0x100 -> both granted in one cycle. Both rd_vld=1 next cycle with identical data.
- All four requesters held continuously for 8 cycles -> each gets exactly 4 grants. Grant pairs rotate {0,1},{2,3},{0,1},{2,3}.
- Read granted, rstn pulsed low before the next edge -> rd_vld stays 0; after release, gnt resumes from requester 0.
- Half write len=1 at 0x202, data 0xBEEF, then word read 0x200 -> rd_data[31:16]=0xBEEF, lower half unchanged.

Source files
------------

// File: rtl/scalar_bank_arb.sv
// Round-robin arbiter sharing the two ports of a dual-port scalar bank among NREQ requesters.
// Port 1 takes the next non-conflicting requester after the port-0 winner; reads route back.
module scalar_bank_arb #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned BYTE_AW = 12,
  parameter int unsigned DW      = 32,
  parameter int unsigned IW      = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_we,
  input  logic [2*NREQ-1:0]       req_len,
  input  logic [BYTE_AW*NREQ-1:0] req_adr,
  input  logic [DW*NREQ-1:0]      req_din,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rd_vld,
  output logic [DW*NREQ-1:0]      rd_data,
  output logic                    bank_re0,
  output logic                    bank_re1,
  output logic                    bank_we0,
  output logic                    bank_we1,
  output logic [1:0]              bank_len0,
  output logic [1:0]              bank_len1,
  output logic [BYTE_AW-1:0]      bank_adr0,
  output logic [BYTE_AW-1:0]      bank_adr1,
  output logic [DW-1:0]           bank_din0,
  output logic [DW-1:0]           bank_din1,
  input  logic [DW-1:0]           bank_dout0,
  input  logic [DW-1:0]           bank_dout1,
  input  logic                    bank_dout0_vld,
  input  logic                    bank_dout1_vld
);

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          own0_vld_q, own1_vld_q;
  logic [IW-1:0] own0_idx_q, own1_idx_q;

  logic          p0_vld, p1_vld;
  logic [IW-1:0] p0_idx, p1_idx, last_idx;
  logic [NREQ-1:0] req_act;

  logic [BYTE_AW-3:0] word_adr [NREQ];
  logic [BYTE_AW-1:0] adr_a    [NREQ];
  logic [1:0]         len_a    [NREQ];
  logic [DW-1:0]      din_a    [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_unpack
    assign adr_a[g]    = req_adr[g*BYTE_AW +: BYTE_AW];
    assign word_adr[g] = req_adr[g*BYTE_AW+2 +: BYTE_AW-2];
    assign len_a[g]    = req_len[g*2 +: 2];
    assign din_a[g]    = req_din[g*DW +: DW];
  end

  function automatic logic [IW-1:0] rot(input logic [IW-1:0] base, input int unsigned off);
    return IW'((int'(base) + off) % NREQ);
  endfunction

  // Requests are masked during reset so nothing reaches the bank or the pointer.
  assign req_act = req & {NREQ{rstn}};

  always_comb begin
    p0_vld = 1'b0;
    p0_idx = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!p0_vld && req_act[rot(rr_ptr_q, k)]) begin
        p0_vld = 1'b1;
        p0_idx = rot(rr_ptr_q, k);
      end
    end
  end

  // A same-word candidate is skipped only when either side writes.
  always_comb begin
    p1_vld = 1'b0;
    p1_idx = '0;
    for (int unsigned k = 1; k < NREQ; k++) begin
      if (p0_vld && !p1_vld && req_act[rot(p0_idx, k)] &&
          !((word_adr[rot(p0_idx, k)] == word_adr[p0_idx]) &&
            (req_we[rot(p0_idx, k)] || req_we[p0_idx]))) begin
        p1_vld = 1'b1;
        p1_idx = rot(p0_idx, k);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (p0_vld) gnt[p0_idx] = 1'b1;
    if (p1_vld) gnt[p1_idx] = 1'b1;
  end

  assign bank_re0  = p0_vld & ~req_we[p0_idx];
  assign bank_we0  = p0_vld &  req_we[p0_idx];
  assign bank_len0 = p0_vld ? len_a[p0_idx] : '0;
  assign bank_adr0 = p0_vld ? adr_a[p0_idx] : '0;
  assign bank_din0 = p0_vld ? din_a[p0_idx] : '0;

  assign bank_re1  = p1_vld & ~req_we[p1_idx];
  assign bank_we1  = p1_vld &  req_we[p1_idx];
  assign bank_len1 = p1_vld ? len_a[p1_idx] : '0;
  assign bank_adr1 = p1_vld ? adr_a[p1_idx] : '0;
  assign bank_din1 = p1_vld ? din_a[p1_idx] : '0;

  assign last_idx = p1_vld ? p1_idx : p0_idx;
  assign rr_ptr_d = p0_vld ? rot(last_idx, 1) : rr_ptr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      own0_vld_q <= 1'b0;
      own1_vld_q <= 1'b0;
      own0_idx_q <= '0;
      own1_idx_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      own0_vld_q <= bank_re0;
      own1_vld_q <= bank_re1;
      own0_idx_q <= p0_idx;
      own1_idx_q <= p1_idx;
    end
  end

  always_comb begin
    rd_vld  = '0;
    rd_data = '0;
    if (own0_vld_q && bank_dout0_vld) begin
      rd_vld[own0_idx_q]             = 1'b1;
      rd_data[own0_idx_q*DW +: DW]   = bank_dout0;
    end
    if (own1_vld_q && bank_dout1_vld) begin
      rd_vld[own1_idx_q]             = 1'b1;
      rd_data[own1_idx_q*DW +: DW]   = bank_dout1;
    end
  end

`ifndef SYNTHESIS
  a_bank0_ret: assert property (@(posedge clk) disable iff (!rstn) own0_vld_q |-> bank_dout0_vld)
    else $error("bank port 0 missed read return");
  a_bank1_ret: assert property (@(posedge clk) disable iff (!rstn) own1_vld_q |-> bank_dout1_vld)
    else $error("bank port 1 missed read return");
`endif

endmodule
